// File: rtl/qpu_ifu_ifetch.sv
// Instruction fetch unit: one outstanding memory request, an instruction register
// feeding the decoder, and static backward-taken branch prediction.
//
// state  | meaning
// S_REQ  | present fetch address at pc, wait for memory to accept
// S_RSP  | request outstanding, capture response into IR
// S_OUT  | IR valid toward decoder, advance pc on handshake
// S_DROP | redirected while a request was outstanding, discard its response
module qpu_ifu_ifetch #(
    parameter int unsigned        PC_SIZE  = 32,
    parameter logic [PC_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               o_ifu_req_valid,
    input  logic               i_ifu_req_ready,
    output logic [PC_SIZE-1:0] o_ifu_req_addr,
    input  logic               i_ifu_rsp_valid,
    output logic               o_ifu_rsp_ready,
    input  logic [31:0]        i_ifu_rsp_instr,
    input  logic               i_ifu_rsp_err,
    output logic               o_ifu_o_valid,
    input  logic               i_ifu_o_ready,
    output logic [31:0]        o_ifu_o_instr,
    output logic [PC_SIZE-1:0] o_ifu_o_pc,
    output logic               o_ifu_o_prdt_taken,
    output logic               o_ifu_o_err,
    input  logic               i_pipe_flush_req,
    input  logic [PC_SIZE-1:0] i_pipe_flush_pc,
    output logic               o_pipe_flush_ack
);

    typedef enum logic [1:0] {S_REQ, S_RSP, S_OUT, S_DROP} state_t;

    localparam logic [PC_SIZE-1:0] LP_PC_INC   = PC_SIZE'(4);
    localparam logic [PC_SIZE-1:0] LP_RESET_PC = {RESET_PC[PC_SIZE-1:2], 2'b00};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_SIZE-1:0] r_pc;
    logic [PC_SIZE-1:0] r_next_pc;
    logic [PC_SIZE-1:0] r_ir_pc;
    logic [31:0]        r_ir_instr;
    logic               r_ir_prdt;
    logic               r_ir_err;

    logic               w_req_hs;
    logic               w_rsp_hs;
    logic               w_out_hs;
    logic               w_capture;
    logic               w_is_branch;
    logic               w_prdt;
    logic [PC_SIZE-1:0] w_flush_pc;
    logic [PC_SIZE-1:0] w_b_imm;
    logic [PC_SIZE-1:0] w_cap_next_pc;
    logic               w_unused;

    assign w_flush_pc = {i_pipe_flush_pc[PC_SIZE-1:2], 2'b00};
    assign w_req_hs   = o_ifu_req_valid & i_ifu_req_ready;
    assign w_rsp_hs   = i_ifu_rsp_valid & o_ifu_rsp_ready;
    assign w_out_hs   = o_ifu_o_valid & i_ifu_o_ready;
    assign w_capture  = (r_state == S_RSP) & w_rsp_hs & ~i_pipe_flush_req;

    // A faulted fetch is never predicted taken, so its successor is always pc+4.
    assign w_is_branch   = ~i_ifu_rsp_instr[0] & (i_ifu_rsp_instr[4:0] == 5'b11000);
    assign w_prdt        = w_is_branch & i_ifu_rsp_instr[9] & ~i_ifu_rsp_err;
    assign w_b_imm       = {{(PC_SIZE-14){i_ifu_rsp_instr[9]}}, i_ifu_rsp_instr[9:5],
                            i_ifu_rsp_instr[23:15]};
    assign w_cap_next_pc = r_pc + (w_prdt ? {w_b_imm[PC_SIZE-3:0], 2'b00} : LP_PC_INC);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_req_hs) w_state_nxt = S_RSP;
            end
            S_RSP: begin
                if (i_pipe_flush_req)     w_state_nxt = i_ifu_rsp_valid ? S_REQ : S_DROP;
                else if (i_ifu_rsp_valid) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (i_pipe_flush_req || i_ifu_o_ready) w_state_nxt = S_REQ;
            end
            S_DROP: begin
                if (i_ifu_rsp_valid) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        o_ifu_req_valid = 1'b0;
        o_ifu_rsp_ready = 1'b0;
        o_ifu_o_valid   = 1'b0;
        case (r_state)
            S_REQ:         o_ifu_req_valid = ~i_pipe_flush_req;
            S_RSP, S_DROP: o_ifu_rsp_ready = 1'b1;
            S_OUT:         o_ifu_o_valid   = ~i_pipe_flush_req;
            default:       ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= LP_RESET_PC;
            r_next_pc  <= '0;
            r_ir_pc    <= '0;
            r_ir_instr <= '0;
            r_ir_prdt  <= 1'b0;
            r_ir_err   <= 1'b0;
        end else begin
            if (i_pipe_flush_req) begin
                r_pc <= w_flush_pc;
            end else if (w_out_hs) begin
                r_pc <= r_next_pc;
            end
            if (w_capture) begin
                r_ir_instr <= i_ifu_rsp_instr;
                r_ir_pc    <= r_pc;
                r_ir_err   <= i_ifu_rsp_err;
                r_ir_prdt  <= w_prdt;
                r_next_pc  <= w_cap_next_pc;
            end
        end
    end

    assign o_ifu_req_addr     = r_pc;
    assign o_ifu_o_instr      = r_ir_instr;
    assign o_ifu_o_pc         = r_ir_pc;
    assign o_ifu_o_prdt_taken = r_ir_prdt;
    assign o_ifu_o_err        = r_ir_err;
    assign o_pipe_flush_ack   = i_pipe_flush_req;

    assign w_unused = &{1'b0, i_pipe_flush_pc[1:0], i_ifu_rsp_instr[31:24], i_ifu_rsp_instr[14:10]};

endmodule

// File: tb/tb_qpu_ifu_ifetch.sv
// Bench for qpu_ifu_ifetch: behavioural instruction memory and decoder, with a
// scoreboard of expected IR contents filled on accepted responses.
module tb_qpu_ifu_ifetch;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] W_ADDI   = 32'h0000_0042;
    localparam logic [31:0] W_BR_BWD = 32'h00FE_03F8;
    localparam logic [31:0] W_BR_FWD = 32'h00FE_0018;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_ifu_req_valid;
    logic        i_ifu_req_ready;
    logic [31:0] o_ifu_req_addr;
    logic        i_ifu_rsp_valid;
    logic        o_ifu_rsp_ready;
    logic [31:0] i_ifu_rsp_instr;
    logic        i_ifu_rsp_err;
    logic        o_ifu_o_valid;
    logic        i_ifu_o_ready;
    logic [31:0] o_ifu_o_instr;
    logic [31:0] o_ifu_o_pc;
    logic        o_ifu_o_prdt_taken;
    logic        o_ifu_o_err;
    logic        i_pipe_flush_req;
    logic [31:0] i_pipe_flush_pc;
    logic        o_pipe_flush_ack;

    always #5 clk = ~clk;

    qpu_ifu_ifetch #(.PC_SIZE(32), .RESET_PC(RST_PC)) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .o_ifu_req_valid    (o_ifu_req_valid),
        .i_ifu_req_ready    (i_ifu_req_ready),
        .o_ifu_req_addr     (o_ifu_req_addr),
        .i_ifu_rsp_valid    (i_ifu_rsp_valid),
        .o_ifu_rsp_ready    (o_ifu_rsp_ready),
        .i_ifu_rsp_instr    (i_ifu_rsp_instr),
        .i_ifu_rsp_err      (i_ifu_rsp_err),
        .o_ifu_o_valid      (o_ifu_o_valid),
        .i_ifu_o_ready      (i_ifu_o_ready),
        .o_ifu_o_instr      (o_ifu_o_instr),
        .o_ifu_o_pc         (o_ifu_o_pc),
        .o_ifu_o_prdt_taken (o_ifu_o_prdt_taken),
        .o_ifu_o_err        (o_ifu_o_err),
        .i_pipe_flush_req   (i_pipe_flush_req),
        .i_pipe_flush_pc    (i_pipe_flush_pc),
        .o_pipe_flush_ack   (o_pipe_flush_ack)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        prdt;
        logic        err;
        logic [31:0] nxt;
    } ir_t;

    ir_t         sb[$];
    logic [31:0] mem [logic [31:0]];
    bit          err_mem [logic [31:0]];

    int          n_chk = 0;
    int          n_err = 0;

    bit          rst_v, flush_v, dec_ready, after_rst, lat_chk;
    logic [31:0] flush_pc_v;
    bit          mem_busy, drop_pend;
    int          mem_lat, mem_cnt;
    logic [31:0] mem_addr, exp_next, last_req_addr;
    int          cyc, last_out_cyc, out_cnt, n0;
    bit          req_seen, out_seen, ov_seen;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : W_ADDI;
    endfunction

    function automatic bit err_at(input logic [31:0] a);
        return err_mem.exists(a) ? err_mem[a] : 1'b0;
    endfunction

    function automatic ir_t ref_item(input logic [31:0] pc, input logic [31:0] ins, input logic e);
        ir_t         r;
        logic [31:0] imm;
        r.instr = ins;
        r.pc    = pc;
        r.err   = e;
        r.prdt  = (ins[4:0] == 5'b11000) && ins[9] && !e;
        imm     = {{18{ins[9]}}, ins[9:5], ins[23:15]};
        r.nxt   = r.prdt ? pc + (imm << 2) : pc + 32'd4;
        return r;
    endfunction

    // One clock: drive at negedge, observe just after, update the memory/scoreboard model.
    task automatic step();
        bit  rsp_hs, req_hs, out_hs;
        ir_t it;
        @(negedge clk);
        i_rst            = rst_v;
        i_ifu_req_ready  = 1'b1;
        i_ifu_rsp_valid  = mem_busy && (mem_cnt == 0);
        i_ifu_rsp_instr  = mem_busy ? word_at(mem_addr) : 32'h0;
        i_ifu_rsp_err    = mem_busy && err_at(mem_addr);
        i_ifu_o_ready    = dec_ready;
        i_pipe_flush_req = flush_v;
        i_pipe_flush_pc  = flush_pc_v;
        #1;
        cyc++;
        req_seen = 1'b0;
        out_seen = 1'b0;
        ov_seen  = 1'b0;
        if (rst_v) begin
            mem_busy     = 1'b0;
            drop_pend    = 1'b0;
            sb.delete();
            exp_next     = RST_PC;
            after_rst    = 1'b1;
            last_out_cyc = -1;
            return;
        end
        if (after_rst) begin
            after_rst = 1'b0;
            chk("rst_req_valid", 32'(o_ifu_req_valid), 1);
            chk("rst_req_addr", o_ifu_req_addr, RST_PC);
            chk("rst_o_valid", 32'(o_ifu_o_valid), 0);
            chk("rst_rsp_ready", 32'(o_ifu_rsp_ready), 0);
            chk("rst_ir_instr", o_ifu_o_instr, 0);
            chk("rst_ir_pc", o_ifu_o_pc, 0);
            chk("rst_ir_prdt", 32'(o_ifu_o_prdt_taken), 0);
            chk("rst_ir_err", 32'(o_ifu_o_err), 0);
        end
        chk("flush_ack", 32'(o_pipe_flush_ack), 32'(flush_v));
        rsp_hs = i_ifu_rsp_valid & o_ifu_rsp_ready;
        req_hs = o_ifu_req_valid & i_ifu_req_ready;
        out_hs = o_ifu_o_valid & i_ifu_o_ready;
        if (flush_v) begin
            chk("flush_req_valid", 32'(o_ifu_req_valid), 0);
            chk("flush_o_valid", 32'(o_ifu_o_valid), 0);
        end
        if (o_ifu_req_valid) chk("req_rsp_ready", 32'(o_ifu_rsp_ready), 0);
        if (o_ifu_o_valid) begin
            ov_seen = 1'b1;
            chk("out_rsp_ready", 32'(o_ifu_rsp_ready), 0);
            chk("out_req_valid", 32'(o_ifu_req_valid), 0);
            chk("out_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                chk("out_instr", o_ifu_o_instr, sb[0].instr);
                chk("out_pc", o_ifu_o_pc, sb[0].pc);
                chk("out_prdt", 32'(o_ifu_o_prdt_taken), 32'(sb[0].prdt));
                chk("out_err", 32'(o_ifu_o_err), 32'(sb[0].err));
            end
        end
        if (req_hs) begin
            req_seen      = 1'b1;
            last_req_addr = o_ifu_req_addr;
            chk("req_outstanding", 32'(mem_busy), 0);
            chk("req_addr", o_ifu_req_addr, exp_next);
        end
        if (rsp_hs) begin
            if (!flush_v && !drop_pend)
                sb.push_back(ref_item(mem_addr, i_ifu_rsp_instr, i_ifu_rsp_err));
            drop_pend = 1'b0;
            mem_busy  = 1'b0;
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
        end
        if (flush_v) begin
            if (mem_busy) drop_pend = 1'b1;
            sb.delete();
            exp_next = {flush_pc_v[31:2], 2'b00};
        end
        if (out_hs) begin
            out_seen = 1'b1;
            out_cnt++;
            if (sb.size() > 0) begin
                it       = sb.pop_front();
                exp_next = it.nxt;
            end
            if (lat_chk && last_out_cyc >= 0) chk("out_spacing", cyc - last_out_cyc, 3);
            last_out_cyc = cyc;
        end
        if (req_hs) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = o_ifu_req_addr;
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        step();
        step();
        rst_v = 1'b0;
        step();
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush_v    = 1'b1;
        flush_pc_v = pc;
        step();
        flush_v    = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            step();
            if (req_seen) return;
        end
        chk({tag, "_timeout"}, 32'(req_seen), 1);
    endtask

    task automatic wait_out(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            step();
            if (out_seen) return;
        end
        chk({tag, "_timeout"}, 32'(out_seen), 1);
    endtask

    task automatic wait_ov(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            step();
            if (ov_seen) return;
        end
        chk({tag, "_timeout"}, 32'(ov_seen), 1);
    endtask

    initial begin
        i_rst = 1'b1; i_ifu_req_ready = 1'b0; i_ifu_rsp_valid = 1'b0;
        i_ifu_rsp_instr = '0; i_ifu_rsp_err = 1'b0; i_ifu_o_ready = 1'b0;
        i_pipe_flush_req = 1'b0; i_pipe_flush_pc = '0;
        rst_v = 1'b0; flush_v = 1'b0; flush_pc_v = '0; dec_ready = 1'b1;
        after_rst = 1'b0; lat_chk = 1'b0; mem_busy = 1'b0; drop_pend = 1'b0;
        mem_lat = 0; mem_cnt = 0; mem_addr = '0; exp_next = RST_PC; last_req_addr = '0;
        cyc = 0; last_out_cyc = -1; out_cnt = 0; n0 = 0;

        do_reset();

        // zero-wait stream of addi words
        lat_chk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_out("t1_out", 10);
            chk("t1_pc", o_ifu_o_pc, 32'(k * 4));
            chk("t1_prdt", 32'(o_ifu_o_prdt_taken), 0);
        end
        lat_chk = 1'b0;

        // backward branch at 0x100
        mem[32'h100] = W_BR_BWD;
        do_flush(32'h100);
        wait_out("t2_out", 15);
        chk("t2_pc", o_ifu_o_pc, 32'h100);
        chk("t2_prdt", 32'(o_ifu_o_prdt_taken), 1);
        wait_req("t2_req", 10);
        chk("t2_next_addr", last_req_addr, 32'h0F0);

        // forward branch with decoder stalled
        mem[32'h100] = W_BR_FWD;
        dec_ready = 1'b0;
        do_flush(32'h100);
        wait_ov("t3_ov", 15);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_stall_no_req", 32'(o_ifu_req_valid), 0);
            chk("t3_hold_instr", o_ifu_o_instr, W_BR_FWD);
        end
        dec_ready = 1'b1;
        wait_out("t3_out", 5);
        chk("t3_prdt", 32'(o_ifu_o_prdt_taken), 0);
        wait_req("t3_req", 10);
        chk("t3_next_addr", last_req_addr, 32'h104);

        // flush while waiting for a slow response
        mem_lat = 2;
        wait_req("t4_req", 15);
        n0 = out_cnt;
        do_flush(32'h203);
        wait_req("t4_req2", 15);
        chk("t4_next_addr", last_req_addr, 32'h200);
        chk("t4_no_out", out_cnt - n0, 0);

        // flush coincident with the response
        mem_lat = 0;
        wait_req("t4b_req", 15);
        n0 = out_cnt;
        do_flush(32'h300);
        wait_req("t4b_req2", 10);
        chk("t4b_next_addr", last_req_addr, 32'h300);
        chk("t4b_no_out", out_cnt - n0, 0);

        // flush coincident with decoder ready in S_OUT
        dec_ready = 1'b0;
        wait_ov("t5_ov", 15);
        dec_ready = 1'b1;
        n0 = out_cnt;
        do_flush(32'h400);
        chk("t5_no_out", out_cnt - n0, 0);
        wait_req("t5_req", 10);
        chk("t5_next_addr", last_req_addr, 32'h400);

        // bus error on a backward branch word
        mem[32'h500]     = W_BR_BWD;
        err_mem[32'h500] = 1'b1;
        do_flush(32'h500);
        wait_out("t6_out", 15);
        chk("t6_err", 32'(o_ifu_o_err), 1);
        chk("t6_prdt", 32'(o_ifu_o_prdt_taken), 0);
        wait_req("t6_req", 10);
        chk("t6_next_addr", last_req_addr, 32'h504);

        // pc wrap at the top of the address space
        do_flush(32'hFFFF_FFFC);
        wait_out("t6w_out", 15);
        chk("t6w_pc", o_ifu_o_pc, 32'hFFFF_FFFC);
        wait_req("t6w_req", 10);
        chk("t6w_next_addr", last_req_addr, 32'h0);

        // reset with a loaded IR
        dec_ready = 1'b0;
        wait_ov("t7_ov", 15);
        dec_ready = 1'b1;
        do_reset();
        wait_out("t7_out", 10);
        chk("t7_pc", o_ifu_o_pc, RST_PC);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/qpu_ifu_ifetch.md
QPU_IFU_IFETCH -- requirements
Module: QPU_ifu_ifetch

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, width of all PC/address ports.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ifu_req_valid  output  1  fetch request to instruction memory.
REQ-006 ifu_req_ready  input  1  memory accepts request.
REQ-007 ifu_req_addr  output  PC_SIZE  fetch address, bits [1:0] always 0.
REQ-008 ifu_rsp_valid  input  1  memory response valid.
REQ-009 ifu_rsp_ready  output  1  block accepts response.
REQ-010 ifu_rsp_instr  input  32  fetched instruction word.
REQ-011 ifu_rsp_err  input  1  fetch bus error.
REQ-012 ifu_o_valid  output  1  IR holds instruction for decoder.
REQ-013 ifu_o_ready  input  1  decoder/EXU accepts IR.
REQ-014 ifu_o_instr  output  32  instruction to decoder i_instr.
REQ-015 ifu_o_pc  output  PC_SIZE  PC of ifu_o_instr, to decoder i_pc.
REQ-016 ifu_o_prdt_taken  output  1  static prediction, to decoder i_prdt_taken.
REQ-017 ifu_o_err  output  1  instruction carries fetch error.
REQ-018 pipe_flush_req  input  1  redirect from EXU (mispredict).
REQ-019 pipe_flush_pc  input  PC_SIZE  redirect target.
REQ-020 pipe_flush_ack  output  1  redirect accepted; equals pipe_flush_req every cycle.

Function
REQ-021 FSM states SHALL be S_REQ, S_RSP, S_OUT, S_DROP; one request outstanding at most.
REQ-022 S_REQ: ifu_req_valid = ~pipe_flush_req, ifu_req_addr = pc; req handshake -> S_RSP.
REQ-023 S_RSP: ifu_rsp_ready = 1; rsp handshake without flush -> capture instr/pc/err into IR, -> S_OUT.
REQ-024 S_OUT: ifu_o_valid = ~pipe_flush_req; o handshake -> pc <= next_pc, -> S_REQ; IR outputs stable while valid & ~ready.
REQ-025 S_DROP: ifu_rsp_ready = 1; rsp handshake discarded, -> S_REQ; ifu_o_valid = 0.
REQ-026 ifu_rsp_ready SHALL be 0 in S_REQ and S_OUT; ifu_req_valid 0 outside S_REQ.
REQ-027 Branch detect: instr[0]==0 & instr[4:0]==5'b11000.
REQ-028 b_imm = sign-extend to PC_SIZE of {instr[9:5], instr[23:15]} (14 bits, sign instr[9]).
REQ-029 Predict taken iff branch & instr[9]==1 & ~err (backward taken); else not taken.
REQ-030 next_pc = pc + (b_imm << 2) if predicted taken, else pc + 4; modulo 2^PC_SIZE, wrap silently.
REQ-031 ifu_o_prdt_taken SHALL be registered with IR; next_pc computed at capture, held with IR.
REQ-032 Flush in S_REQ or S_OUT: pc <= {pipe_flush_pc[PC_SIZE-1:2],2'b00}, -> S_REQ; held IR discarded.
REQ-033 Flush in S_RSP: pc <= aligned flush pc; -> S_REQ if rsp handshake same cycle (response dropped), else -> S_DROP.
REQ-034 Flush in S_DROP: pc <= aligned flush pc, stay S_DROP until response.
REQ-035 Flush SHALL take priority over every handshake in the same cycle; no IR handshake occurs in a flush cycle.
REQ-036 ifu_rsp_err=1: IR captured with ifu_o_err=1, prdt_taken=0, next_pc=pc+4.
REQ-037 Latency: zero-wait memory and ready decoder -> one instruction per 3 cycles.

Reset
REQ-038 rst=1 at clock edge SHALL set state S_REQ, pc=RESET_PC, IR instr/pc/prdt/err = 0, regardless of state (including outstanding request; its response is not tracked).
REQ-039 First cycle after reset: ifu_req_valid=1, ifu_req_addr=RESET_PC, ifu_o_valid=0, ifu_rsp_ready=0.

Verification
REQ-040 Reset, zero-wait memory returning addi (32'h0000_0042) -> req addrs 0,4,8, each IR prdt_taken=0, o_valid every 3rd cycle.
REQ-041 At pc 0x100 return backward beq instr[9]=1, imm=-4 (14'h3FFC) -> o_prdt_taken=1, next req addr 0x0F0.
REQ-042 Forward branch instr[9]=0 at 0x100 -> prdt_taken=0, next addr 0x104; ifu_o_ready low 5 cycles -> IR stable, no new req.
REQ-043 Flush pc 0x203 while in S_RSP, response 2 cycles later -> flush_ack=1, response dropped, o_valid stays 0, next req addr 0x200.
REQ-044 Flush coincident with ifu_o_ready in S_OUT -> o_valid=0 that cycle, next req addr = flush pc.
REQ-045 ifu_rsp_err=1 on backward branch word -> o_err=1, prdt_taken=0, next addr pc+4; pc 0xFFFF_FFFC advance -> wraps to 0x0.
